// File: rtl/imem_pkg.sv
// Shared types, constants and the address-check helper for the instruction-memory fetch responder.
package imem_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST          = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } imem_rsp_t;

  // 33-bit unsigned bounds so a window ending at the top of the address space cannot wrap.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned depth);
    logic [32:0] limit;
    limit = {1'b0, base} + ({1'b0, depth} << 2);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} < {1'b0, base}) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO with flush; no bypass, so a pushed entry is visible from the next cycle.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  imem_rsp_t        push_data,
  input  logic             pop,
  output imem_rsp_t        pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  imem_rsp_t        entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the response outputs read as zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries <= '{default: '0};
    end else if (do_push && !flush) begin
      entries[wr_ptr] <= push_data;
    end
  end

  assign pop_data = entries[rd_ptr];

  overflow_push: assert property (@(posedge clk) disable iff (reset || flush)
                                  !(push && full && !pop));

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch-side instruction memory responder: sync-read memory, fixed-latency pipeline and credit-checked response FIFO.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEFAULT,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned RSP_FIFO_DEPTH = 4,
  parameter string       INIT_FILE      = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid_if1,
  output logic        req_ready_if1,
  input  logic [31:0] req_addr_if1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic [31:0] rsp_addr,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(RSP_FIFO_DEPTH + LATENCY + 1);

  logic [31:0] mem [DEPTH_WORDS];

  logic               accept;
  logic               req_err;
  logic [IDX_W+1:0]   byte_offset;
  logic [IDX_W-1:0]   word_idx;
  logic [LATENCY-1:0] pipe_valid;
  imem_rsp_t          pipe_data [LATENCY];
  imem_rsp_t          head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [OCC_W-1:0]   occupancy;

  assign accept      = req_valid_if1 && req_ready_if1;
  assign req_err     = addr_err(req_addr_if1, BASE_ADDR, DEPTH_WORDS);
  assign byte_offset = req_addr_if1[IDX_W+1:0] - BASE_ADDR[IDX_W+1:0];
  assign word_idx    = IDX_W'(byte_offset >> 2);

  // Every in-flight request already owns a FIFO slot, so the FIFO can never be pushed while full.
  always_comb begin
    occupancy = OCC_W'(fifo_count) + OCC_W'($countones(pipe_valid));
  end

  assign req_ready_if1 = !reset && !flush && (occupancy < OCC_W'(RSP_FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid <= LATENCY'({pipe_valid, accept});
    end
  end

  // Stage 1 performs the synchronous read; errored fetches substitute a NOP without touching memory.
  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_data[0].addr <= req_addr_if1;
      pipe_data[0].err  <= req_err;
      pipe_data[0].inst <= req_err ? NOP_INST : mem[word_idx];
    end
    for (int i = 1; i < int'(LATENCY); i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  imem_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (pipe_valid[LATENCY-1]),
    .push_data (pipe_data[LATENCY-1]),
    .pop       (rsp_ready),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_inst  = head.inst;
  assign rsp_addr  = head.addr;
  assign rsp_err   = head.err;

  full_blocks_requests: assert property (@(posedge clk) disable iff (reset)
                                         fifo_full |-> !req_ready_if1);

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: expected responses are queued on accept and compared on each pop.
`timescale 1ns/1ps
module tb_imem_fetch_responder;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req_valid_if1;
  logic        req_ready_if1;
  logic [31:0] req_addr_if1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  int          num_checks = 0;
  int          num_fail   = 0;
  int          rsp_count  = 0;
  imem_rsp_t   sb [$];
  imem_rsp_t   exp_rsp;

  always #5 clk = ~clk;

  imem_fetch_responder dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .req_valid_if1 (req_valid_if1),
    .req_ready_if1 (req_ready_if1),
    .req_addr_if1  (req_addr_if1),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_inst      (rsp_inst),
    .rsp_addr      (rsp_addr),
    .rsp_err       (rsp_err)
  );

  function automatic logic [31:0] mem_model(input int i);
    if (i == 0) return 32'h0000_0297;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0001;
  endfunction

  // Independent model: 4 KiB window at 0x8000_0000, word aligned, NOP on error.
  function automatic imem_rsp_t expectRsp(input logic [31:0] a);
    imem_rsp_t r;
    r.addr = a;
    r.err  = (a[1:0] != 2'b00) || (a < 32'h8000_0000) || (a >= 32'h8000_1000);
    r.inst = r.err ? 32'h0000_0013 : mem_model(int'((a - 32'h8000_0000) >> 2));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic r, input logic f);
    req_valid_if1 = v;
    req_addr_if1  = a;
    rsp_ready     = r;
    flush         = f;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Starts mid-cycle with an empty DUT; the request is accepted at the end of cycle 0.
  task automatic checkSingleFetch();
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("lat_cycle1_valid", 32'(rsp_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("lat_cycle2_valid", 32'(rsp_valid), 32'd1);
    checkOutput("lat_cycle2_inst", rsp_inst, 32'h0000_0297);
    checkOutput("lat_cycle2_addr", rsp_addr, 32'h8000_0000);
    checkOutput("lat_cycle2_err", 32'(rsp_err), 32'd0);
    nextCycle();
  endtask

  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        if (sb.size() == 0) begin
          checkOutput("spurious_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          exp_rsp = sb.pop_front();
          checkOutput("rsp_inst", rsp_inst, exp_rsp.inst);
          checkOutput("rsp_addr", rsp_addr, exp_rsp.addr);
          checkOutput("rsp_err", 32'(rsp_err), 32'(exp_rsp.err));
        end
      end
      if (req_valid_if1 && req_ready_if1) sb.push_back(expectRsp(req_addr_if1));
    end
  end

  initial begin
    int          base_count;
    int          acc;
    logic [31:0] err_addrs [6];

    reset = 1'b1;
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 1024; i++) dut.mem[i] = mem_model(i);

    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready_if1), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_inst", rsp_inst, 32'd0);
    checkOutput("rst_rsp_addr", rsp_addr, 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    nextCycle();
    reset = 1'b0;
    checkSingleFetch();

    // Streaming at full rate.
    base_count = rsp_count;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("stream_ready", 32'(req_ready_if1), 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (4) nextCycle();
    checkOutput("stream_count", 32'(rsp_count - base_count), 32'd8);

    // Backpressure: credits run out after RSP_FIFO_DEPTH accepts.
    base_count = rsp_count;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h8000_0040 + 32'(4 * acc), 1'b0, 1'b0);
      @(negedge clk);
      if (req_ready_if1) acc++;
      if (rsp_valid) begin
        checkOutput("bp_head_addr", rsp_addr, 32'h8000_0040);
        checkOutput("bp_head_inst", rsp_inst, mem_model(16));
      end
      nextCycle();
    end
    checkOutput("bp_accepted", 32'(acc), 32'd4);
    @(negedge clk);
    checkOutput("bp_ready_low", 32'(req_ready_if1), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (8) nextCycle();
    checkOutput("bp_drained", 32'(rsp_count - base_count), 32'd4);

    // Error and boundary addresses.
    err_addrs = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_1000,
                  32'h8000_0FFC, 32'hFFFF_FFFC, 32'h8000_0FFD};
    base_count = rsp_count;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, err_addrs[i], 1'b1, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (5) nextCycle();
    checkOutput("err_count", 32'(rsp_count - base_count), 32'd6);

    // Flush with three queued and one in flight.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h8000_0100 + 32'(4 * i), 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h8000_0200, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flush_no_accept", 32'(req_ready_if1), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("flush_inflight_gone", 32'(rsp_valid), 32'd0);
    checkOutput("flush_ready_back", 32'(req_ready_if1), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h8000_0030, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flush_idle_ready", 32'(req_ready_if1), 32'd0);
    nextCycle();
    base_count = rsp_count;
    applyStimulus(1'b1, 32'h8000_0010, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (4) nextCycle();
    checkOutput("flush_after_count", 32'(rsp_count - base_count), 32'd1);

    // Reset while the FIFO holds two entries.
    applyStimulus(1'b1, 32'h8000_0020, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'h8000_0024, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("pre_reset_valid", 32'(rsp_valid), 32'd1);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_rsp_inst", rsp_inst, 32'd0);
    checkOutput("midrst_rsp_addr", rsp_addr, 32'd0);
    checkOutput("midrst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready_if1), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("midrst_hold_valid", 32'(rsp_valid), 32'd0);
    nextCycle();
    reset = 1'b0;
    checkSingleFetch();

    repeat (3) nextCycle();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
